pktgen_scheduler: RTL and testbench
===================================

Name: pktgen_scheduler

Overview:
- Sequences the two packet-generator channels whose per-channel busy flags feed the status register block.
- Accepts one command: channel mask, mode, round count. Pulses each channel's start, tracks its busy flag through rise and fall, and repeats for N rounds.
- Reports completion, timeout or abort to the AXI control logic.
- Sits between the AXI control register block and the channel generators.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for a channel's busy to reach its expected level (idle before launch, high after start).
- CNT_W, 16: width of the round counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  scheduler can accept a command
- cmd_mask  in  2  channel select, bit0=ch0, bit1=ch1
- cmd_mode  in  1  0=sequential, 1=parallel
- cmd_rounds  in  CNT_W  number of rounds
- abort  in  1  stop the current command
- ch_busy  in  2  channel busy flags, already synchronized to clk
- ch_start  out  2  one-cycle start pulses to the channels
- sched_busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command ends
- status  out  2  result: 0=OK, 1=timeout, 2=aborted, 3=bad command
- rounds_left  out  CNT_W  rounds not yet completed

Behaviour:
- Reset (async, active-high):
  - State=IDLE.
  - ch_start=0, done=0, status=0, rounds_left=0, sched_busy=0.
  - cmd_ready=1 once reset deasserts.
- Registers and outputs:
  - cmd_ready=1 only in IDLE. sched_busy = (state != IDLE).
  - Accept on cmd_valid & cmd_ready: latch mask, mode, rounds; load rounds_left=cmd_rounds.
- Bad command (mask==0 or rounds==0): no ch_start. done=1 with status=3 on the cycle after accept; back to IDLE.
- States:
  - IDLE → PRECHK on accept.
  - PRECHK: wait until all targeted channels have busy=0.
    - Sequential: targeted = current channel (lowest set bit of mask first).
    - Parallel: targeted = all channels in mask.
    - Timeout counter runs. Reaching TIMEOUT_CYCLES → FINISH with status=1.
    - The first PRECHK cycle with all targets idle → LAUNCH.
  - LAUNCH: ch_start=targets for exactly one cycle; clear the rise flags; → WAIT_RISE.
  - WAIT_RISE:
    - Latch a per-channel rise flag when ch_busy is seen high, from the cycle after the start pulse onward.
    - All targets risen → WAIT_FALL.
    - Timeout counter (cleared on entry) reaching TIMEOUT_CYCLES → FINISH with status=1.
  - WAIT_FALL: all targets ch_busy=0 → NEXT. No timeout; packet runs are unbounded.
  - NEXT:
    - Sequential with a higher mask bit not yet run: select that channel → PRECHK.
    - Otherwise the round is complete: rounds_left -= 1. rounds_left==0 → FINISH with status=0, else reset to the lowest channel → PRECHK.
  - FINISH: done=1 for one cycle, status updated; → IDLE.
- Status retention: status holds until the next accept, then reads 0 while that command runs.
- Abort:
  - Sampled in any state other than IDLE or FINISH; takes priority over all other transitions.
  - Next state is FINISH with status=2. No ch_start is issued in the abort cycle or later.
  - rounds_left freezes at its current value. Abort in IDLE is ignored.
- Simultaneous events:
  - abort and timeout on the same cycle → status=2.
  - Rise and timeout on the same cycle → the rise wins (no timeout).
- Counters:
  - The timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits and saturates.
  - rounds_left does not wrap; the decrement happens only when it is nonzero.
- Latency:
  - Accept to first ch_start is 2 cycles if targets are idle (PRECHK, then LAUNCH).
  - Final busy fall to done pulse is 2 cycles (NEXT, FINISH).

Test Plan:
- Sequential, mask=2'b11, rounds=2, each channel busy for 10 cycles starting 3 cycles after start → ch_start sequence 01,10,01,10; rounds_left goes 2→1→0; done with status=0.
- Parallel, mask=2'b11, rounds=1, ch0 busy 5 cycles, ch1 busy 20 cycles → single ch_start=11; done 2 cycles after ch1 falls; status=0.
- mask=2'b01, rounds=1, ch0 never asserts busy → done exactly TIMEOUT_CYCLES cycles after entering WAIT_RISE, plus the FINISH cycle; status=1; ch_start pulsed once.
- mask=2'b11, rounds=3, abort pulsed mid-WAIT_FALL of round 2 → done next+1 cycle, status=2; rounds_left=2; no further ch_start.
- cmd_rounds=0 or cmd_mask=0 → no ch_start; done on the cycle after accept; status=3; cmd_ready=1 the cycle after done.
- reset asserted mid-WAIT_RISE → outputs clear asynchronously; a fresh command is accepted after deassert and runs normally.

Source files
------------

// File: rtl/pktgen_scheduler.sv
// pktgen_scheduler: runs start/busy handshakes on two packet channels
// for N rounds and reports OK, timeout, abort or bad command.
module pktgen_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mask,
  input  logic             cmd_mode,
  input  logic [CNT_W-1:0] cmd_rounds,
  input  logic             abort,
  input  logic [1:0]       ch_busy,
  output logic [1:0]       ch_start,
  output logic             sched_busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] rounds_left
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_TMO = 2'd1;
  localparam logic [1:0] ST_ABT = 2'd2;
  localparam logic [1:0] ST_BAD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHK,
    S_LAUNCH,
    S_WRISE,
    S_WFALL,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t           state_q;
  logic [1:0]       mask_q;
  logic             mode_q;
  logic             cur_q;
  logic [1:0]       rise_q;
  logic [TW-1:0]    tmr_q;
  logic [1:0]       start_q;
  logic             done_q;
  logic [1:0]       status_q;
  logic [CNT_W-1:0] rl_q;

  logic [1:0]       tgt;
  logic [1:0]       rise_d;
  logic [TW-1:0]    tmr_d;
  logic [CNT_W-1:0] rl_d;
  logic             all_risen;
  logic             all_idle;
  logic             tmo;
  logic             last_ch;
  logic             active;

  // Targets of the current launch and the derived wait conditions
  always_comb begin
    tgt       = mode_q ? mask_q : (cur_q ? 2'b10 : 2'b01);
    rise_d    = rise_q | (ch_busy & tgt);
    all_risen = (rise_d & tgt) == tgt;
    all_idle  = (ch_busy & tgt) == 2'b00;
    tmo       = tmr_q >= TMAX;
    tmr_d     = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
    rl_d      = (rl_q != '0) ? rl_q - CNT_W'(1) : rl_q;
    last_ch   = mode_q | cur_q | ~mask_q[1];
    active    = (state_q != S_IDLE) && (state_q != S_FINISH);
  end

  // Scheduler FSM with registered start/done/status/rounds outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      mode_q   <= 1'b0;
      cur_q    <= 1'b0;
      rise_q   <= '0;
      tmr_q    <= '0;
      start_q  <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      rl_q     <= '0;
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      if (active && abort) begin
        status_q <= ST_ABT;
        done_q   <= 1'b1;
        state_q  <= S_FINISH;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_valid) begin
              mask_q <= cmd_mask;
              mode_q <= cmd_mode;
              rl_q   <= cmd_rounds;
              cur_q  <= ~cmd_mask[0];
              tmr_q  <= '0;
              if (cmd_mask == 2'b00 || cmd_rounds == '0) begin
                status_q <= ST_BAD;
                done_q   <= 1'b1;
                state_q  <= S_FINISH;
              end else begin
                status_q <= ST_OK;
                state_q  <= S_PRECHK;
              end
            end
          end
          S_PRECHK: begin
            if (all_idle) begin
              start_q <= tgt;
              state_q <= S_LAUNCH;
            end else if (tmo) begin
              status_q <= ST_TMO;
              done_q   <= 1'b1;
              state_q  <= S_FINISH;
            end else begin
              tmr_q <= tmr_d;
            end
          end
          S_LAUNCH: begin
            rise_q  <= '0;
            tmr_q   <= '0;
            state_q <= S_WRISE;
          end
          S_WRISE: begin
            rise_q <= rise_d;
            if (all_risen) begin
              state_q <= S_WFALL;
            end else if (tmo) begin
              status_q <= ST_TMO;
              done_q   <= 1'b1;
              state_q  <= S_FINISH;
            end else begin
              tmr_q <= tmr_d;
            end
          end
          S_WFALL: begin
            if (all_idle) state_q <= S_NEXT;
          end
          S_NEXT: begin
            tmr_q <= '0;
            if (!last_ch) begin
              cur_q   <= 1'b1;
              state_q <= S_PRECHK;
            end else begin
              rl_q <= rl_d;
              if (rl_d == '0) begin
                status_q <= ST_OK;
                done_q   <= 1'b1;
                state_q  <= S_FINISH;
              end else begin
                cur_q   <= ~mask_q[0];
                state_q <= S_PRECHK;
              end
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) & ~reset;
  assign sched_busy  = state_q != S_IDLE;
  assign ch_start    = start_q;
  assign done        = done_q;
  assign status      = status_q;
  assign rounds_left = rl_q;

endmodule

// File: tb/tb_pktgen_scheduler.sv
// tb_pktgen_scheduler: drives commands against modelled channels and
// compares start pulses and completion against a timeline model.
module tb_pktgen_scheduler;

  localparam int T  = 40;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mask;
  logic          cmd_mode;
  logic [CW-1:0] cmd_rounds;
  logic          abort;
  logic [1:0]    ch_busy = '0;
  logic [1:0]    ch_start;
  logic          sched_busy;
  logic          done;
  logic [1:0]    status;
  logic [CW-1:0] rounds_left;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int dly[2];
  int len[2];
  bit never[2];
  bit st[2];
  int s_at[2];

  int            p_cyc[$];
  logic [1:0]    p_val[$];
  logic [CW-1:0] p_rl[$];
  logic [1:0]    p_st[$];
  int            d_cnt;
  int            d_cyc;
  logic [1:0]    d_st;
  logic [CW-1:0] d_rl;

  int         e_cyc[$];
  logic [1:0] e_val[$];
  int         e_rl[$];
  int         e_done;
  int         e_st;
  int         e_drl;

  pktgen_scheduler #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask),
    .cmd_mode(cmd_mode),
    .cmd_rounds(cmd_rounds),
    .abort(abort),
    .ch_busy(ch_busy),
    .ch_start(ch_start),
    .sched_busy(sched_busy),
    .done(done),
    .status(status),
    .rounds_left(rounds_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Channel responders and output monitor, evaluated mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      st[0] = 1'b0;
      st[1] = 1'b0;
      ch_busy = '0;
    end else begin
      if (ch_start != 2'b00) begin
        p_cyc.push_back(cyc);
        p_val.push_back(ch_start);
        p_rl.push_back(rounds_left);
        p_st.push_back(status);
      end
      if (done) begin
        d_cnt++;
        d_cyc = cyc;
        d_st  = status;
        d_rl  = rounds_left;
      end
      for (int i = 0; i < 2; i++) begin
        if (ch_start[i]) begin
          st[i]   = 1'b1;
          s_at[i] = cyc;
        end
        ch_busy[i] = st[i] && !never[i] && cyc >= s_at[i] + dly[i]
                     && cyc < s_at[i] + dly[i] + len[i];
      end
    end
  end

  // Expected pulse timeline: launch at s, channel busy [s+d, s+d+L),
  // next launch 3 cycles after last fall, done 2 cycles after it.
  function automatic void predict(logic [1:0] m, logic md, int r_n, int a);
    logic [1:0] ll[$];
    int s;
    int f;
    int x;
    e_cyc.delete();
    e_val.delete();
    e_rl.delete();
    if (md) ll.push_back(m);
    else begin
      if (m[0]) ll.push_back(2'b01);
      if (m[1]) ll.push_back(2'b10);
    end
    s = a + 2;
    for (int r = 1; r <= r_n; r++) begin
      for (int j = 0; j < ll.size(); j++) begin
        e_cyc.push_back(s);
        e_val.push_back(ll[j]);
        e_rl.push_back(r_n - r + 1);
        if ((ll[j][0] && never[0]) || (ll[j][1] && never[1])) begin
          e_done = s + T + 2;
          e_st   = 1;
          e_drl  = r_n - r + 1;
          return;
        end
        f = 0;
        for (int i = 0; i < 2; i++) begin
          if (ll[j][i]) begin
            x = dly[i] + len[i];
            if (x > f) f = x;
          end
        end
        f = s + f;
        if (r == r_n && j == ll.size() - 1) begin
          e_done = f + 2;
          e_st   = 0;
          e_drl  = 0;
        end else begin
          s = f + 3;
        end
      end
    end
  endfunction

  task automatic issue(input logic [1:0] m, input logic md,
                       input int r_n, output int a);
    int n = 0;
    p_cyc.delete();
    p_val.delete();
    p_rl.delete();
    p_st.delete();
    d_cnt = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: got %b, want 1", cmd_ready);
    end
    cmd_mask   = m;
    cmd_mode   = md;
    cmd_rounds = CW'(r_n);
    cmd_valid  = 1'b1;
    a = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (d_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (d_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, want 1", nm, d_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_mask = '0;
    cmd_mode = 1'b0;
    cmd_rounds = '0;
    abort = 1'b0;
    dly = '{1, 1};
    len = '{1, 1};
    never = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    checks++;
    if (ch_start !== 2'b00) begin
      errors++;
      $display("FAIL rst_start: got %b, want 00", ch_start);
    end
    checks++;
    if (done !== 1'b0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_done_busy: got %b%b, want 00", done, sched_busy);
    end
    checks++;
    if (status !== 2'd0 || rounds_left !== '0) begin
      errors++;
      $display("FAIL rst_stat_rl: got %0d/%0d, want 0/0", status, rounds_left);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got rdy=%b busy=%b, want 1 0", cmd_ready, sched_busy);
    end
  endtask

  task automatic test_sequential();
    int a;
    dly = '{3, 3};
    len = '{10, 10};
    never = '{1'b0, 1'b0};
    issue(2'b11, 1'b0, 2, a);
    predict(2'b11, 1'b0, 2, a);
    wait_done("seq", 600);
    checks++;
    if (p_cyc.size() != e_cyc.size()) begin
      errors++;
      $display("FAIL seq_npulse: got %0d, want %0d", p_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < p_cyc.size() && i < e_cyc.size(); i++) begin
      checks++;
      if (p_cyc[i] !== e_cyc[i] || p_val[i] !== e_val[i] || p_rl[i] !== CW'(e_rl[i])) begin
        errors++;
        $display("FAIL seq_pulse%0d: got c=%0d v=%b rl=%0d, want c=%0d v=%b rl=%0d",
                 i, p_cyc[i], p_val[i], p_rl[i], e_cyc[i], e_val[i], e_rl[i]);
      end
    end
    checks++;
    if (d_cyc !== e_done || d_st !== 2'(e_st) || d_rl !== CW'(e_drl)) begin
      errors++;
      $display("FAIL seq_done: got c=%0d st=%0d rl=%0d, want c=%0d st=%0d rl=%0d",
               d_cyc, d_st, d_rl, e_done, e_st, e_drl);
    end
  endtask

  task automatic test_timeout();
    int a;
    dly = '{2, 2};
    len = '{4, 4};
    never = '{1'b1, 1'b0};
    issue(2'b01, 1'b0, 1, a);
    predict(2'b01, 1'b0, 1, a);
    wait_done("tmo", 300);
    checks++;
    if (p_cyc.size() != 1 || p_cyc.size() != e_cyc.size()) begin
      errors++;
      $display("FAIL tmo_npulse: got %0d, want 1", p_cyc.size());
    end else if (p_cyc[0] !== e_cyc[0] || p_val[0] !== 2'b01) begin
      errors++;
      $display("FAIL tmo_pulse: got c=%0d v=%b, want c=%0d v=01", p_cyc[0], p_val[0], e_cyc[0]);
    end
    checks++;
    if (d_cyc !== e_done || d_st !== 2'(e_st) || d_rl !== CW'(e_drl)) begin
      errors++;
      $display("FAIL tmo_done: got c=%0d st=%0d rl=%0d, want c=%0d st=%0d rl=%0d",
               d_cyc, d_st, d_rl, e_done, e_st, e_drl);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (status !== 2'd1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hold: got st=%0d rdy=%b, want 1 1", status, cmd_ready);
    end
    never = '{1'b0, 1'b0};
  endtask

  task automatic test_parallel();
    int a;
    dly = '{2, 3};
    len = '{5, 20};
    never = '{1'b0, 1'b0};
    issue(2'b11, 1'b1, 1, a);
    predict(2'b11, 1'b1, 1, a);
    wait_done("par", 600);
    checks++;
    if (p_cyc.size() != 1) begin
      errors++;
      $display("FAIL par_npulse: got %0d, want 1", p_cyc.size());
    end else begin
      checks++;
      if (p_cyc[0] !== e_cyc[0] || p_val[0] !== 2'b11 || p_st[0] !== 2'd0) begin
        errors++;
        $display("FAIL par_pulse: got c=%0d v=%b st=%0d, want c=%0d v=11 st=0",
                 p_cyc[0], p_val[0], p_st[0], e_cyc[0]);
      end
    end
    checks++;
    if (d_cyc !== e_done || d_st !== 2'(e_st) || d_rl !== CW'(e_drl)) begin
      errors++;
      $display("FAIL par_done: got c=%0d st=%0d rl=%0d, want c=%0d st=%0d rl=%0d",
               d_cyc, d_st, d_rl, e_done, e_st, e_drl);
    end
  endtask

  task automatic test_abort();
    int a;
    int n = 0;
    dly = '{3, 3};
    len = '{10, 10};
    never = '{1'b0, 1'b0};
    issue(2'b11, 1'b0, 3, a);
    while (p_cyc.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (p_cyc.size() < 3) begin
      errors++;
      $display("FAIL abt_reach: got %0d pulses, want 3", p_cyc.size());
      return;
    end
    a = p_cyc[2] + 7;
    while (cyc < a) @(negedge clk);
    abort = 1'b1;
    a = cyc;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abt", 50);
    repeat (30) @(negedge clk);
    checks++;
    if (d_cyc !== a + 1 || d_st !== 2'd2 || d_rl !== CW'(2)) begin
      errors++;
      $display("FAIL abt_done: got c=%0d st=%0d rl=%0d, want c=%0d st=2 rl=2",
               d_cyc, d_st, d_rl, a + 1);
    end
    checks++;
    if (p_cyc.size() != 3 || d_cnt != 1 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL abt_after: got pulses=%0d dones=%0d busy=%b, want 3 1 0",
               p_cyc.size(), d_cnt, sched_busy);
    end
  endtask

  task automatic test_bad_cmd();
    logic [1:0] bm[2];
    int br[2];
    int a;
    bm = '{2'b00, 2'b10};
    br = '{3, 0};
    for (int k = 0; k < 2; k++) begin
      issue(bm[k], 1'b0, br[k], a);
      checks++;
      if (done !== 1'b1 || status !== 2'd3 || cyc !== a + 1) begin
        errors++;
        $display("FAIL bad%0d_done: got done=%b st=%0d cyc=%0d, want 1 3 %0d",
                 k, done, status, cyc, a + 1);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || rounds_left !== CW'(br[k])) begin
        errors++;
        $display("FAIL bad%0d_after: got rdy=%b done=%b rl=%0d, want 1 0 %0d",
                 k, cmd_ready, done, rounds_left, br[k]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (p_cyc.size() != 0 || d_cnt != 1) begin
        errors++;
        $display("FAIL bad%0d_pulses: got pulses=%0d dones=%0d, want 0 1",
                 k, p_cyc.size(), d_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    int n = 0;
    dly = '{8, 2};
    len = '{5, 4};
    never = '{1'b0, 1'b0};
    issue(2'b01, 1'b0, 1, a);
    while (p_cyc.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rounds_left !== CW'(1) || sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: got rl=%0d busy=%b, want 1 1", rounds_left, sched_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ch_start !== 2'b00 || done !== 1'b0 || status !== 2'd0 ||
        rounds_left !== '0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_clear: got st=%b d=%b s=%0d rl=%0d b=%b, want all 0",
               ch_start, done, status, rounds_left, sched_busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dly = '{3, 2};
    len = '{6, 4};
    issue(2'b10, 1'b0, 2, a);
    predict(2'b10, 1'b0, 2, a);
    wait_done("rmid", 400);
    checks++;
    if (p_cyc.size() != e_cyc.size()) begin
      errors++;
      $display("FAIL rmid_npulse: got %0d, want %0d", p_cyc.size(), e_cyc.size());
    end
    for (int i = 0; i < p_cyc.size() && i < e_cyc.size(); i++) begin
      checks++;
      if (p_cyc[i] !== e_cyc[i] || p_val[i] !== e_val[i]) begin
        errors++;
        $display("FAIL rmid_pulse%0d: got c=%0d v=%b, want c=%0d v=%b",
                 i, p_cyc[i], p_val[i], e_cyc[i], e_val[i]);
      end
    end
    checks++;
    if (d_cyc !== e_done || d_st !== 2'(e_st) || d_rl !== CW'(e_drl)) begin
      errors++;
      $display("FAIL rmid_done: got c=%0d st=%0d rl=%0d, want c=%0d st=%0d rl=%0d",
               d_cyc, d_st, d_rl, e_done, e_st, e_drl);
    end
  endtask

  task automatic test_random();
    int a;
    logic [1:0] m;
    logic md;
    int r_n;
    for (int it = 0; it < 12; it++) begin
      m   = 2'($urandom_range(1, 3));
      md  = 1'($urandom_range(0, 1));
      r_n = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        dly[i]   = $urandom_range(1, 6);
        len[i]   = $urandom_range(1, 12);
        never[i] = ($urandom_range(0, 9) == 0);
      end
      issue(m, md, r_n, a);
      predict(m, md, r_n, a);
      wait_done("rnd", 600);
      checks++;
      if (p_cyc.size() != e_cyc.size()) begin
        errors++;
        $display("FAIL rnd%0d_npulse: got %0d, want %0d", it, p_cyc.size(), e_cyc.size());
      end
      for (int i = 0; i < p_cyc.size() && i < e_cyc.size(); i++) begin
        checks++;
        if (p_cyc[i] !== e_cyc[i] || p_val[i] !== e_val[i] ||
            p_rl[i] !== CW'(e_rl[i]) || p_st[i] !== 2'd0) begin
          errors++;
          $display("FAIL rnd%0d_pulse%0d: got c=%0d v=%b rl=%0d st=%0d, want c=%0d v=%b rl=%0d st=0",
                   it, i, p_cyc[i], p_val[i], p_rl[i], p_st[i], e_cyc[i], e_val[i], e_rl[i]);
        end
      end
      checks++;
      if (d_cyc !== e_done || d_st !== 2'(e_st) || d_rl !== CW'(e_drl)) begin
        errors++;
        $display("FAIL rnd%0d_done: got c=%0d st=%0d rl=%0d, want c=%0d st=%0d rl=%0d",
                 it, d_cyc, d_st, d_rl, e_done, e_st, e_drl);
      end
    end
    never = '{1'b0, 1'b0};
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_timeout();
    test_parallel();
    repeat (5) @(negedge clk);
    test_abort();
    repeat (20) @(negedge clk);
    test_bad_cmd();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
